// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full_adder reused over N clock cycles,
// start/busy/done handshake, registered result held between operations.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module serial_adder_ctrl #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         c_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    y_q, y_d;
  // Only the upper N-1 bits of the sum shifter are kept: bit 0 of a full
  // N-bit shifter would be shifted out on the final edge and never read.
  logic [N-2:0]    sr_q, sr_d;
  logic            c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    s_q, s_d;
  logic            cout_q, cout_d;

  logic            fa_sum;
  logic            fa_carry;

  full_adder u_fa (
    .a_i (x_q[0]),
    .b_i (y_q[0]),
    .c_i (c_q),
    .s_o (fa_sum),
    .c_o (fa_carry)
  );

  // State and datapath registers, cleared asynchronously on reset
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and shift-and-add sequencing
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sr_d    = sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          c_d     = c_in;
          cnt_d   = CW'(N - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d = (N-1)'({fa_sum, sr_q} >> 1);
        x_d  = x_q >> 1;
        y_d  = y_q >> 1;
        c_d  = fa_carry;
        if (cnt_q == '0) begin
          s_d     = {fa_sum, sr_q};
          cout_d  = fa_carry;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign s     = s_q;
  assign c_out = cout_q;

endmodule
